serial_lane_arbiter: RTL and testbench
======================================

// Module: serial_lane_arbiter
// PURPOSE
//  Shares one serial output lane between NREQ parallel-word requesters.
//  Round-robin arbitration picks one requester per frame; the accepted word is shifted out MSB-first.
//  Each frame lasts WIDTH cycles, with a frame strobe and the source id alongside.
//  Sits between the parallel producers and the serial shift-register link.
// PARAMETERS
//  NREQ     2  number of requesters (>=2)
//  WIDTH    4  bits per word/frame (>=2)
//  IDLE_GAP 1  forced idle cycles after each frame (>=0)
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high
//  req_valid  in   NREQ         requester i has a word pending
//  req_data   in   NREQ*WIDTH   word i = req_data[i*WIDTH +: WIDTH]
//  req_ready  out  NREQ         one-hot; word i accepted on edge where valid[i]&ready[i]
//  serial_out out  1            serial bit, MSB first; 0 outside a frame
//  frame      out  1            high for exactly WIDTH cycles per frame
//  grant_id   out  IDW          source of current frame; IDW = max(1,$clog2(NREQ))
//  busy       out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset clock/reset: clk; reset asynchronous, active-high.
//  - Reset values: state=IDLE, serial_out=0, frame=0, grant_id=0, busy=0, shreg=0, bitcnt=0.
//  - Reset value of rr pointer: last_grant=NREQ-1, so req0 has highest priority first.
//  - FSM states: IDLE, SHIFT, GAP.
//  - IDLE: winner = first i with req_valid[i], searching (last_grant+1) mod NREQ upward with wrap.
//    req_ready[winner]=1, combinational from state and req_valid; all other ready bits 0.
//    No valid -> ready all 0, stay IDLE.
//  - Accept edge k:
//    - shreg <= word, grant_id <= winner, last_grant <= winner.
//    - bitcnt <= WIDTH-1, state <= SHIFT.
//  - SHIFT: frame=1.
//    - serial_out = shreg[WIDTH-1] (registered path); bits appear in cycles k..k+WIDTH-1.
//    - Each edge: shreg <= {shreg[WIDTH-2:0],1'b0}, bitcnt--.
//    - At bitcnt==0 edge: frame<=0, serial_out<=0.
//      Then go to GAP if IDLE_GAP>0 (gap counter = IDLE_GAP-1), else go to IDLE.
//  - GAP: outputs idle; leave to IDLE when gap counter reaches 0.
//  - Frame period under continuous demand: WIDTH+IDLE_GAP+1 cycles (IDLE costs one cycle).
//  - req_ready is 0 in SHIFT/GAP. Requesters hold valid/data until accepted.
//    Dropping valid while not accepted is legal, and that requester is simply skipped.
//  - grant_id holds its value after a frame until the next accept.
//  - Reset mid-frame aborts immediately with no partial bits after reset.
//    All outputs go to reset values and the pointer returns to last_grant=NREQ-1.
//  - No parameter-driven width truncation; bitcnt and gap counters are sized by $clog2 of their max.
// STRUCTURE
//  - Shared package serial_lane_pkg: state enum {IDLE,SHIFT,GAP}; IDW/counter-width helper function.
//  - One sub-module rr_arbiter: inputs req, last_grant; outputs one-hot grant and encoded winner id.
//  - Shift register, counters and FSM stay inline in serial_lane_arbiter.
// TESTING
//  1. Reset held, then released with no valid -> serial_out=0, frame=0, busy=0, req_ready=0, grant_id=0.
//  2. NREQ=2, WIDTH=4, req0 valid data=4'b1011
//     -> ready[0] for 1 cycle; frame high 4 cycles.
//     -> serial_out 1,0,1,1; grant_id=0; busy high for 4+1 cycles.
//  3. Both valid continuously (d0=4'hA, d1=4'h5)
//     -> grants 0,1,0,1.
//     -> frame rising edges 6 cycles apart; serial 1010 then 0101.
//  4. Reset pulsed after 2 bits of a req1 frame
//     -> next cycle frame=0, serial_out=0.
//     -> with both valid, first grant after reset is req0.
//  5. NREQ=3, IDLE_GAP=0, only req2 valid with data 4'hF
//     -> back-to-back frames every 5 cycles, grant_id=2, serial all 1s within frame.
//  6. IDLE_GAP=3, req0 valid -> 3 GAP cycles with busy=1, req_ready=0 before the next accept.

Source files
------------

// File: rtl/serial_lane_pkg.sv
// Shared types and sizing helpers for the serial lane arbiter.
package serial_lane_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_lane_if.sv
// Requester-side handshake and serial lane outputs of the arbiter.
interface serial_lane_if import serial_lane_pkg::*; #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) ();
    localparam int IDW = cnt_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  serial_out;
    logic                  frame;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, serial_out, frame, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, serial_out, frame, grant_id, busy
    );
endinterface

// File: rtl/serial_lane_arbiter_rr_arbiter.sv
// Round-robin pick: first request strictly after last_grant, wrapping to the lowest index.
module rr_arbiter import serial_lane_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IDW  = cnt_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);
    logic [NREQ-1:0] upper_grant;
    logic [NREQ-1:0] any_grant;
    logic            seen_upper;
    logic            seen_any;

    // Two priority encoders: one over indices above last_grant, one over all; the upper one wins.
    always_comb begin
        upper_grant = '0;
        any_grant   = '0;
        seen_upper  = 1'b0;
        seen_any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !seen_any) begin
                any_grant[i] = 1'b1;
                seen_any     = 1'b1;
            end
            if (req[i] && (IDW'(i) > last_grant) && !seen_upper) begin
                upper_grant[i] = 1'b1;
                seen_upper     = 1'b1;
            end
        end
        grant    = seen_upper ? upper_grant : any_grant;
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = IDW'(i);
        end
    end
endmodule

// File: rtl/serial_lane_arbiter.sv
// Shares one serial lane among NREQ word producers; each accepted word goes out MSB-first
// as a WIDTH-cycle frame followed by IDLE_GAP idle cycles.
module serial_lane_arbiter import serial_lane_pkg::*; #(
    parameter int NREQ     = 2,
    parameter int WIDTH    = 4,
    parameter int IDLE_GAP = 1
) (
    input logic         clk,
    input logic         reset,
    serial_lane_if.slave bus
);
    localparam int IDW = cnt_width(NREQ);
    localparam int BCW = cnt_width(WIDTH);
    localparam int GCW = cnt_width(IDLE_GAP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [GCW-1:0]   gapcnt_q, gapcnt_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic             serial_q, serial_d;
    logic             frame_q, frame_d;

    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_id;
    logic [WIDTH-1:0] masked_word [NREQ];
    logic [WIDTH-1:0] win_word;
    logic             accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_id   (arb_id)
    );

    // One-hot word select: mask every word by its grant bit, then OR them together.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign masked_word[gi] = bus.req_data[gi*WIDTH +: WIDTH] & {WIDTH{arb_grant[gi]}};
    end

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NREQ; i++) win_word = win_word | masked_word[i];
    end

    assign accept = (state_q == IDLE) && (|arb_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            gapcnt_q     <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            serial_q     <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            gapcnt_q     <= gapcnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            serial_q     <= serial_d;
            frame_q      <= frame_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        gapcnt_d     = gapcnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        serial_d     = serial_q;
        frame_d      = frame_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d      = win_word;
                    grant_id_d   = arb_id;
                    last_grant_d = arb_id;
                    bitcnt_d     = BCW'(WIDTH - 1);
                    serial_d     = win_word[WIDTH-1];
                    frame_d      = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // serial_q already shows shreg MSB, so the next bit is the one below it.
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                serial_d = shreg_q[WIDTH-2];
                bitcnt_d = bitcnt_q - 1'b1;
                if (bitcnt_q == '0) begin
                    bitcnt_d = '0;
                    serial_d = 1'b0;
                    frame_d  = 1'b0;
                    if (IDLE_GAP > 0) begin
                        gapcnt_d = GCW'(IDLE_GAP - 1);
                        state_d  = GAP;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            GAP: begin
                if (gapcnt_q == '0) state_d  = IDLE;
                else                gapcnt_d = gapcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) ? arb_grant : '0;
        bus.busy       = (state_q != IDLE);
        bus.serial_out = serial_q;
        bus.frame      = frame_q;
        bus.grant_id   = grant_id_q;
    end
endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Scoreboard bench: expected frames are queued as stimulus is driven and checked as frames leave the lane.
module tb_serial_lane_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_lane_if #(.NREQ(2), .WIDTH(4)) bus_a ();
    serial_lane_if #(.NREQ(3), .WIDTH(4)) bus_b ();
    serial_lane_if #(.NREQ(2), .WIDTH(4)) bus_c ();

    serial_lane_arbiter #(.NREQ(2), .WIDTH(4), .IDLE_GAP(1)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    serial_lane_arbiter #(.NREQ(3), .WIDTH(4), .IDLE_GAP(0)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    serial_lane_arbiter #(.NREQ(2), .WIDTH(4), .IDLE_GAP(3)) u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    localparam int W = 4;

    logic [2:0]  drv_valid [3] = '{default: '0};
    logic [11:0] drv_data  [3] = '{default: '0};

    assign bus_a.req_valid = drv_valid[0][1:0];
    assign bus_a.req_data  = drv_data[0][7:0];
    assign bus_b.req_valid = drv_valid[1];
    assign bus_b.req_data  = drv_data[1];
    assign bus_c.req_valid = drv_valid[2][1:0];
    assign bus_c.req_data  = drv_data[2][7:0];

    typedef struct {
        int inst;
        int id;
        int word;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cap_n     [3] = '{default: 0};
    int cap_bits  [3] = '{default: 0};
    int rise_cnt  [3] = '{default: 0};
    int last_rise [3] = '{default: -1};
    int period    [3] = '{default: 0};
    int gap_exp   [3] = '{default: 0};
    int gap_busy  [3] = '{default: 0};
    int rdy_cnt   [3] = '{default: 0};
    int busy_cnt  [3] = '{default: 0};
    bit prev_fr   [3] = '{default: 1'b0};

    task automatic check_eq(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic mon_step(input int k, input logic fr, input logic so, input int gid,
                            input logic bz, input logic rdy);
        exp_t e;
        if (reset) begin
            cap_n[k]     = 0;
            prev_fr[k]   = 1'b0;
            last_rise[k] = -1;
            gap_busy[k]  = 0;
            return;
        end
        if (bz)  busy_cnt[k]++;
        if (rdy) rdy_cnt[k]++;
        if (fr && !prev_fr[k]) begin
            rise_cnt[k]++;
            if (last_rise[k] >= 0 && period[k] > 0) begin
                check_eq($sformatf("period%0d", k), cyc - last_rise[k], period[k]);
                check_eq($sformatf("gap_busy%0d", k), gap_busy[k], gap_exp[k]);
            end
            last_rise[k] = cyc;
            cap_n[k]     = 1;
            cap_bits[k]  = int'(so);
        end else if (fr) begin
            cap_n[k]++;
            if (cap_n[k] <= W) cap_bits[k] = (cap_bits[k] << 1) | int'(so);
            else if (cap_n[k] == W + 1) check_eq($sformatf("frame_len%0d", k), cap_n[k], W);
        end else begin
            if (prev_fr[k]) begin
                if (cap_n[k] < W) check_eq($sformatf("frame_len%0d", k), cap_n[k], W);
                gap_busy[k] = 0;
            end
            cap_n[k] = 0;
            if (bz && !rdy) gap_busy[k]++;
        end
        if (fr && cap_n[k] == W) begin
            if (exp_q.size() == 0) begin
                check_eq($sformatf("unexpected_frame%0d", k), exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("frame_inst%0d", k), k, e.inst);
                check_eq($sformatf("grant_id%0d", k), gid, e.id);
                check_eq($sformatf("serial_word%0d", k), cap_bits[k], e.word);
            end
        end
        prev_fr[k] = fr;
    endtask

    always @(negedge clk) begin
        mon_step(0, bus_a.frame, bus_a.serial_out, int'(bus_a.grant_id), bus_a.busy, |bus_a.req_ready);
        mon_step(1, bus_b.frame, bus_b.serial_out, int'(bus_b.grant_id), bus_b.busy, |bus_b.req_ready);
        mon_step(2, bus_c.frame, bus_c.serial_out, int'(bus_c.grant_id), bus_c.busy, |bus_c.req_ready);
    end

    task automatic arm(input int k, input int per, input int gap);
        period[k]    = per;
        gap_exp[k]   = gap;
        last_rise[k] = -1;
    endtask

    task automatic push(input int k, input int id, input int word);
        exp_t e;
        e.inst = k;
        e.id   = id;
        e.word = word;
        exp_q.push_back(e);
    endtask

    // Hold the requests until nframes frames have started, then wait for the scoreboard to drain.
    task automatic send(input int k, input logic [2:0] mask, input logic [11:0] data, input int nframes);
        int target;
        int guard;
        target = rise_cnt[k] + nframes;
        @(posedge clk); #1;
        drv_data[k]  = data;
        drv_valid[k] = mask;
        guard = 0;
        while (rise_cnt[k] < target && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        drv_valid[k] = '0;
        check_eq($sformatf("frames_started%0d", k), rise_cnt[k], target);
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        check_eq($sformatf("scoreboard_drained%0d", k), exp_q.size(), 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    int r0, b0, guard;

    initial begin
        // Reset state while asserted and after release with nothing pending.
        repeat (3) @(negedge clk);
        check_eq("rst_frame", int'(bus_a.frame), 0);
        check_eq("rst_busy", int'(bus_a.busy), 0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("idle_serial", int'(bus_a.serial_out), 0);
        check_eq("idle_frame", int'(bus_a.frame), 0);
        check_eq("idle_busy", int'(bus_a.busy), 0);
        check_eq("idle_ready", int'(bus_a.req_ready), 0);
        check_eq("idle_grant_id", int'(bus_a.grant_id), 0);
        check_eq("idle_busy_b", int'(bus_b.busy), 0);
        check_eq("idle_grant_id_b", int'(bus_b.grant_id), 0);
        check_eq("idle_busy_c", int'(bus_c.busy), 0);

        // Single word from requester 0.
        arm(0, 6, 1);
        r0 = rdy_cnt[0];
        b0 = busy_cnt[0];
        push(0, 0, 4'b1011);
        send(0, 3'b001, 12'h00B, 1);
        check_eq("ready_cycles", rdy_cnt[0] - r0, 1);
        check_eq("busy_cycles", busy_cnt[0] - b0, 5);
        check_eq("grant_id_hold0", int'(bus_a.grant_id), 0);

        // Both requesters continuously valid from reset: strict alternation.
        pulse_reset();
        arm(0, 6, 1);
        push(0, 0, 4'hA);
        push(0, 1, 4'h5);
        push(0, 0, 4'hA);
        push(0, 1, 4'h5);
        send(0, 3'b011, 12'h05A, 4);

        // Reset in the middle of a requester-1 frame.
        arm(0, 0, 0);
        @(posedge clk); #1;
        drv_data[0]  = 12'h0C0;
        drv_valid[0] = 3'b010;
        guard = 0;
        while (cap_n[0] < 2 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check_eq("abort_bits_seen", cap_n[0], 2);
        reset = 1'b1;
        drv_valid[0] = '0;
        @(negedge clk);
        check_eq("abort_frame", int'(bus_a.frame), 0);
        check_eq("abort_serial", int'(bus_a.serial_out), 0);
        check_eq("abort_busy", int'(bus_a.busy), 0);
        check_eq("abort_grant_id", int'(bus_a.grant_id), 0);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("post_abort_serial", int'(bus_a.serial_out), 0);
        check_eq("post_abort_frame", int'(bus_a.frame), 0);
        push(0, 0, 4'h3);
        push(0, 1, 4'h6);
        send(0, 3'b011, 12'h063, 2);
        check_eq("grant_id_hold1", int'(bus_a.grant_id), 1);

        // Three requesters, no idle gap, only requester 2 active.
        arm(1, 5, 0);
        push(1, 2, 4'hF);
        push(1, 2, 4'hF);
        push(1, 2, 4'hF);
        send(1, 3'b100, 12'hF00, 3);
        check_eq("grant_id_hold_b", int'(bus_b.grant_id), 2);

        // Three idle-gap cycles between frames.
        arm(2, 8, 3);
        push(2, 0, 4'h9);
        push(2, 0, 4'h9);
        send(2, 3'b001, 12'h009, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
